ram_selection_sorter: RTL and testbench

In-place selection sorter for a single-port, 1-cycle-latency synchronous RAM, and the successor of the team's first-generation sorter. It sorts `len` words starting at `start`. Order direction and signedness are chosen per command. Elements are exchanged by true two-word swaps, and zero/one-length commands are handled. It sits between the command fabric and a shared data RAM and owns the RAM port while busy.

---
 rtl/ram_selection_sorter.sv | 206 ++++++++++++++++++++
 tb/tb_ram_selection_sorter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_selection_sorter.sv
// In-place selection sorter driving a single-port, 1-cycle-latency synchronous RAM.
// Each pass scans the unsorted tail, then swaps the best word into the pass base.
module ram_selection_sorter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  order_valid,
  output logic                  order_ready,
  input  logic [ADDR_WIDTH-1:0] order_start,
  input  logic [LEN_WIDTH-1:0]  order_len,
  input  logic                  order_desc,
  input  logic                  order_signed,
  output logic                  sort_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [2:0] {IDLE, SCAN, LAST, SWAP_A, SWAP_B, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] prev_addr_q;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  pass_q, pass_d;
  logic [LEN_WIDTH-1:0]  n_q, n_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [DATA_WIDTH-1:0] first_q, first_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  desc_q, desc_d;
  logic                  sgn_q, sgn_d;

  logic                  order_ready_d, sort_done_d, ram_wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_d;

  logic                  better;
  logic                  go_next;
  logic                  pass_last;
  logic [DATA_WIDTH-1:0] last_best;
  logic [ADDR_WIDTH-1:0] last_idx;

  // Strict improvement over the running best, so ties keep the earliest index.
  always_comb begin
    better = 1'b0;
    if (sgn_q) begin
      better = desc_q ? ($signed(ram_rd_data) > $signed(best_q))
                      : ($signed(ram_rd_data) < $signed(best_q));
    end else begin
      better = desc_q ? (ram_rd_data > best_q) : (ram_rd_data < best_q);
    end
  end

  assign pass_last = (pass_q == LEN_WIDTH'(len_q - LEN_WIDTH'(2)));

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    pass_d        = pass_q;
    n_d           = n_q;
    k_d           = k_q;
    best_d        = best_q;
    first_d       = first_q;
    idx_d         = idx_q;
    desc_d        = desc_q;
    sgn_d         = sgn_q;
    order_ready_d = order_ready;
    sort_done_d   = 1'b0;
    ram_wr_en_d   = 1'b0;
    ram_addr_d    = ram_addr;
    ram_wr_data_d = ram_wr_data;
    go_next       = 1'b0;
    last_best     = best_q;
    last_idx      = idx_q;

    case (state_q)
      IDLE: begin
        if (order_valid && order_ready) begin
          base_d        = order_start;
          len_d         = order_len;
          desc_d        = order_desc;
          sgn_d         = order_signed;
          order_ready_d = 1'b0;
          if (order_len >= LEN_WIDTH'(2)) begin
            state_d    = SCAN;
            pass_d     = '0;
            n_d        = order_len;
            k_d        = '0;
            ram_addr_d = order_start;
          end else begin
            state_d     = DONE;
            sort_done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // Data returned now belongs to the address presented last cycle.
        if (k_q == LEN_WIDTH'(1)) begin
          best_d  = ram_rd_data;
          first_d = ram_rd_data;
          idx_d   = prev_addr_q;
        end else if (k_q != '0 && better) begin
          best_d = ram_rd_data;
          idx_d  = prev_addr_q;
        end
        if (k_q == LEN_WIDTH'(n_q - LEN_WIDTH'(1))) begin
          state_d = LAST;
        end else begin
          k_d        = LEN_WIDTH'(k_q + LEN_WIDTH'(1));
          ram_addr_d = ADDR_WIDTH'(ram_addr + ADDR_WIDTH'(1));
        end
      end
      LAST: begin
        if (better) begin
          last_best = ram_rd_data;
          last_idx  = prev_addr_q;
        end
        best_d = last_best;
        idx_d  = last_idx;
        if (last_idx != base_q) begin
          state_d       = SWAP_A;
          ram_addr_d    = base_q;
          ram_wr_en_d   = 1'b1;
          ram_wr_data_d = last_best;
        end else begin
          go_next = 1'b1;
        end
      end
      SWAP_A: begin
        state_d       = SWAP_B;
        ram_addr_d    = idx_q;
        ram_wr_en_d   = 1'b1;
        ram_wr_data_d = first_q;
      end
      SWAP_B: go_next = 1'b1;
      DONE: begin
        state_d       = IDLE;
        order_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Advance to the next pass, or finish after pass len-2.
    if (go_next) begin
      if (pass_last) begin
        state_d     = DONE;
        sort_done_d = 1'b1;
      end else begin
        state_d    = SCAN;
        pass_d     = LEN_WIDTH'(pass_q + LEN_WIDTH'(1));
        n_d        = LEN_WIDTH'(n_q - LEN_WIDTH'(1));
        k_d        = '0;
        base_d     = ADDR_WIDTH'(base_q + ADDR_WIDTH'(1));
        ram_addr_d = ADDR_WIDTH'(base_q + ADDR_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      prev_addr_q <= '0;
      len_q       <= '0;
      pass_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      best_q      <= '0;
      first_q     <= '0;
      idx_q       <= '0;
      desc_q      <= 1'b0;
      sgn_q       <= 1'b0;
      order_ready <= 1'b1;
      sort_done   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_data <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      prev_addr_q <= ram_addr;
      len_q       <= len_d;
      pass_q      <= pass_d;
      n_q         <= n_d;
      k_q         <= k_d;
      best_q      <= best_d;
      first_q     <= first_d;
      idx_q       <= idx_d;
      desc_q      <= desc_d;
      sgn_q       <= sgn_d;
      order_ready <= order_ready_d;
      sort_done   <= sort_done_d;
      ram_addr    <= ram_addr_d;
      ram_wr_en   <= ram_wr_en_d;
      ram_wr_data <= ram_wr_data_d;
    end
  end

endmodule

// File: tb/tb_ram_selection_sorter.sv
// Directed bench for ram_selection_sorter: behavioural RAM, result/latency/access checks.
module tb_ram_selection_sorter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        order_valid;
  logic        order_ready;
  logic [15:0] order_start;
  logic [15:0] order_len;
  logic        order_desc;
  logic        order_signed;
  logic        sort_done;
  logic [15:0] ram_addr;
  logic        ram_wr_en;
  logic [15:0] ram_wr_data;
  logic [15:0] ram_rd_data;

  logic [15:0] mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic        track = 1'b0;
  logic [15:0] win_start = '0;
  logic [15:0] win_len = '0;
  int          wr_cnt = 0;
  int          oob_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_selection_sorter dut (
    .clk(clk), .rst_n(rst_n),
    .order_valid(order_valid), .order_ready(order_ready),
    .order_start(order_start), .order_len(order_len),
    .order_desc(order_desc), .order_signed(order_signed),
    .sort_done(sort_done),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  // Single-port RAM, read-before-write, 1-cycle latency; ld_* preloads while idle.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (track) begin
      if (ram_wr_en) wr_cnt <= wr_cnt + 1;
      if (16'(ram_addr - win_start) >= win_len) oob_cnt <= oob_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [15:0] base, input logic [15:0] v0, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 16'(base + 16'(j)); ld_data = v[j];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check4(input string tag, input logic [15:0] base, input logic [15:0] e0,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int j = 0; j < 4; j++)
      check($sformatf("%s[%0d]", tag, j), 32'(mem[16'(base + 16'(j))]), 32'(e[j]));
  endtask

  // Issue one command and count cycles from the accept edge to sort_done high.
  task automatic run_cmd(input logic [15:0] start, input logic [15:0] len, input logic desc,
                         input logic sgn, output int cyc, output int writes, output int oob);
    int w0, o0;
    @(negedge clk);
    order_valid = 1'b1; order_start = start; order_len = len;
    order_desc = desc; order_signed = sgn;
    win_start = start; win_len = len;
    w0 = wr_cnt; o0 = oob_cnt;
    @(posedge clk);
    #1;
    order_valid = 1'b0;
    track = 1'b1;
    cyc = 1;
    while (!sort_done && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    track = 1'b0;
    @(negedge clk);
    writes = wr_cnt - w0;
    oob = oob_cnt - o0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, writes, oob, guard;
    logic [15:0] addr_before;

    rst_n = 1'b0;
    order_valid = 1'b0; order_start = '0; order_len = '0;
    order_desc = 1'b0; order_signed = 1'b0;
    #12;
    check("rst_ready", 32'(order_ready), 32'd1);
    check("rst_done", 32'(sort_done), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_wr_data", 32'(ram_wr_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed ascending: two swaps (pass 0 and pass 2).
    load4(16'h0010, 16'd3, 16'hFFFF, 16'd7, 16'd3);
    run_cmd(16'h0010, 16'd4, 1'b0, 1'b1, cyc, writes, oob);
    check4("sgn_asc", 16'h0010, 16'hFFFF, 16'd3, 16'd3, 16'd7);
    check("sgn_asc_cycles", 32'(cyc), 32'd17);
    check("sgn_asc_writes", 32'(writes), 32'd4);
    check("sgn_asc_oob", 32'(oob), 32'd0);
    check("ready_back", 32'(order_ready), 32'd1);

    // Unsigned ascending: one swap in pass 1.
    load4(16'h0010, 16'd3, 16'hFFFF, 16'd7, 16'd3);
    run_cmd(16'h0010, 16'd4, 1'b0, 1'b0, cyc, writes, oob);
    check4("uns_asc", 16'h0010, 16'd3, 16'd3, 16'd7, 16'hFFFF);
    check("uns_asc_cycles", 32'(cyc), 32'd15);

    // Signed descending: swaps in all three passes.
    load4(16'h0010, 16'd3, 16'hFFFF, 16'd7, 16'd3);
    run_cmd(16'h0010, 16'd4, 1'b1, 1'b1, cyc, writes, oob);
    check4("sgn_desc", 16'h0010, 16'd7, 16'd3, 16'd3, 16'hFFFF);
    check("sgn_desc_cycles", 32'(cyc), 32'd19);

    // Already sorted: no writes, minimum latency.
    load4(16'h0100, 16'd1, 16'd2, 16'd3, 16'd4);
    run_cmd(16'h0100, 16'd4, 1'b0, 1'b0, cyc, writes, oob);
    check4("sorted", 16'h0100, 16'd1, 16'd2, 16'd3, 16'd4);
    check("sorted_cycles", 32'(cyc), 32'd13);
    check("sorted_writes", 32'(writes), 32'd0);

    // Address wrap across 0xFFFF -> 0x0000.
    load4(16'hFFFE, 16'd9, 16'd8, 16'd7, 16'd6);
    run_cmd(16'hFFFE, 16'd4, 1'b0, 1'b0, cyc, writes, oob);
    check4("wrap", 16'hFFFE, 16'd6, 16'd7, 16'd8, 16'd9);
    check("wrap_cycles", 32'(cyc), 32'd17);
    check("wrap_oob", 32'(oob), 32'd0);

    // len=0 accepted, then a held len=1 command accepted once ready returns.
    @(negedge clk);
    addr_before = ram_addr;
    order_valid = 1'b1; order_start = 16'h0200; order_len = 16'd0;
    order_desc = 1'b0; order_signed = 1'b0;
    @(posedge clk);
    #1;
    order_len = 16'd1;
    check("len0_done", 32'(sort_done), 32'd1);
    check("len0_ready", 32'(order_ready), 32'd0);
    check("len0_wr_en", 32'(ram_wr_en), 32'd0);
    @(posedge clk);
    #1;
    check("len0_done_drop", 32'(sort_done), 32'd0);
    check("len0_ready_back", 32'(order_ready), 32'd1);
    @(posedge clk);
    #1;
    order_valid = 1'b0;
    check("len1_done", 32'(sort_done), 32'd1);
    check("len1_ready", 32'(order_ready), 32'd0);
    check("len1_addr", 32'(ram_addr), 32'(addr_before));
    @(posedge clk);
    #1;
    check("len1_ready_back", 32'(order_ready), 32'd1);
    check("len1_done_drop", 32'(sort_done), 32'd0);

    // Reset during the first SWAP_A cycle.
    load4(16'h0010, 16'd3, 16'hFFFF, 16'd7, 16'd3);
    @(negedge clk);
    order_valid = 1'b1; order_start = 16'h0010; order_len = 16'd4;
    order_desc = 1'b0; order_signed = 1'b1;
    @(posedge clk);
    #1;
    order_valid = 1'b0;
    guard = 0;
    while (!ram_wr_en && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("swap_a_reached", 32'(ram_wr_en), 32'd1);
    check("swap_a_addr", 32'(ram_addr), 32'h0010);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(order_ready), 32'd1);
    check("arst_done", 32'(sort_done), 32'd0);
    check("arst_addr", 32'(ram_addr), 32'd0);
    check("arst_wr_en", 32'(ram_wr_en), 32'd0);
    check("arst_wr_data", 32'(ram_wr_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(order_ready), 32'd1);
    load4(16'h0010, 16'd3, 16'hFFFF, 16'd7, 16'd3);
    run_cmd(16'h0010, 16'd4, 1'b0, 1'b1, cyc, writes, oob);
    check4("post_rst", 16'h0010, 16'hFFFF, 16'd3, 16'd3, 16'd7);
    check("post_rst_cycles", 32'(cyc), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
